// File: rtl/uart_frame_rx.sv
// uart_frame_rx
//   Receives one 11-bit serial frame: start (0), 8 data bits MSB first,
//   even parity, stop (1). Two selectable bit periods; the selection is
//   latched at the start edge and held for the whole frame.
//
// Ports
//   clk        : rising-edge system clock (single clock domain)
//   rst_n      : asynchronous active-low reset
//   in         : asynchronous serial line, idle high
//   baud_sel   : 0 = DIV_FAST cycles/bit, 1 = DIV_SLOW cycles/bit
//   data       : last good payload (updated only on a valid stop bit)
//   valid      : one-cycle pulse, data is new
//   parity_err : one-cycle pulse together with valid on a parity mismatch
//   frame_err  : one-cycle pulse when the stop bit is sampled low
//   busy       : high whenever the receiver is not idle
module uart_frame_rx #(
    parameter int unsigned DIV_FAST = 46880,
    parameter int unsigned DIV_SLOW = 93760
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in,
    input  logic       baud_sel,
    output logic [7:0] data,
    output logic       valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [16:0] DIV_F  = 17'(DIV_FAST);
    localparam logic [16:0] DIV_S  = 17'(DIV_SLOW);
    localparam logic [16:0] HALF_F = 17'(DIV_FAST / 2);
    localparam logic [16:0] HALF_S = 17'(DIV_SLOW / 2);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_t;

    state_t      state;
    logic        s1;
    logic        rx_s;
    logic [16:0] div_q;
    logic [16:0] cnt;
    logic [2:0]  bitcnt;
    logic [7:0]  sh;
    logic        par;

    // Even parity: data bits plus parity bit must XOR to zero.
    function automatic logic parity_bad(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1         <= 1'b1;
            rx_s       <= 1'b1;
            state      <= IDLE;
            div_q      <= '0;
            cnt        <= '0;
            bitcnt     <= '0;
            sh         <= '0;
            par        <= 1'b0;
            data       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            s1         <= in;
            rx_s       <= s1;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;

            case (state)
                IDLE: begin
                    // Load half a period (plus the load cycle) so the start
                    // check lands mid-bit; later samples follow at full periods.
                    if (!rx_s) begin
                        div_q  <= baud_sel ? DIV_S : DIV_F;
                        cnt    <= baud_sel ? HALF_S : HALF_F;
                        bitcnt <= '0;
                        state  <= START;
                        busy   <= 1'b1;
                    end
                end

                START: begin
                    if (cnt != 17'd0) begin
                        cnt <= cnt - 17'd1;
                    end else if (rx_s) begin
                        // Line went back high: glitch, not a start bit.
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt   <= div_q - 17'd1;
                        state <= DATA;
                    end
                end

                DATA: begin
                    if (cnt != 17'd0) begin
                        cnt <= cnt - 17'd1;
                    end else begin
                        sh     <= {sh[6:0], rx_s};
                        cnt    <= div_q - 17'd1;
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                end

                PARITY: begin
                    if (cnt != 17'd0) begin
                        cnt <= cnt - 17'd1;
                    end else begin
                        par   <= rx_s;
                        cnt   <= div_q - 17'd1;
                        state <= STOP;
                    end
                end

                STOP: begin
                    if (cnt != 17'd0) begin
                        cnt <= cnt - 17'd1;
                    end else if (rx_s) begin
                        data       <= sh;
                        valid      <= 1'b1;
                        parity_err <= parity_bad(sh, par);
                        state      <= IDLE;
                        busy       <= 1'b0;
                    end else begin
                        frame_err <= 1'b1;
                        state     <= BREAK;
                    end
                end

                BREAK: begin
                    // Stay out of IDLE until the line recovers, otherwise a
                    // held-low line would be read as a stream of start bits.
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx. Bit periods are scaled down (40 / 80
// cycles) so whole frames fit in a short run; all timing relations scale.
module tb_uart_frame_rx;

    localparam int DF = 40;
    localparam int DS = 80;

    logic       clk;
    logic       rst_n;
    logic       in;
    logic       baud_sel;
    logic [7:0] data;
    logic       valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [7:0] last_data = 8'h00;

    typedef struct packed {
        logic       ferr;
        logic [7:0] d;
        logic       perr;
        int         at;
    } exp_t;

    exp_t sb[$];

    uart_frame_rx #(.DIV_FAST(DF), .DIV_SLOW(DS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in         (in),
        .baud_sel   (baud_sel),
        .data       (data),
        .valid      (valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: every pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && (valid === 1'b1 || frame_err === 1'b1 || parity_err === 1'b1)) begin
            exp_t e;
            chk("pulse_exclusive", {31'd0, frame_err & (valid | parity_err)}, 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {31'd0, valid | frame_err}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("frame_err", {31'd0, frame_err}, {31'd0, e.ferr});
                chk("valid", {31'd0, valid}, {31'd0, ~e.ferr});
                chk("data", {24'd0, data}, {24'd0, e.d});
                chk("parity_err", {31'd0, parity_err}, {31'd0, e.perr});
                chk("latency", 32'(cyc), 32'(e.at));
            end
        end
    end

    // Sends one frame; called and returns at posedge+1. flip_at >= 0 toggles
    // baud_sel after that many data bits.
    task automatic send(input logic [7:0] d, input logic p, input logic stop,
                        input logic sel, input int flip_at);
        int   div;
        logic [10:0] bits;
        exp_t e;
        baud_sel = sel;
        div  = sel ? DS : DF;
        bits = {1'b0, d, p, stop};
        // Edge count from drive to the visible pulse: first registering edge,
        // then 10.5 periods plus 3 cycles of sync/load.
        e.at = cyc + 10 * div + div / 2 + 4;
        if (stop) begin
            e.ferr = 1'b0;
            e.d    = d;
            e.perr = ^{d, p};
            last_data = d;
        end else begin
            e.ferr = 1'b1;
            e.d    = last_data;
            e.perr = 1'b0;
        end
        sb.push_back(e);
        for (int i = 10; i >= 0; i--) begin
            if (flip_at >= 0 && i == 9 - flip_at) baud_sel = ~baud_sel;
            in = bits[i];
            repeat (div) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        in       = 1'b1;
        baud_sel = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_data", {24'd0, data}, 32'h00);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_perr", {31'd0, parity_err}, 32'd0);
        chk("rst_ferr", {31'd0, frame_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Good frame, fast rate.
        send(8'hA5, 1'b0, 1'b1, 1'b0, -1);
        repeat (10) @(posedge clk);
        #1;
        chk("sb_empty_a5", 32'(sb.size()), 32'd0);

        // Wrong parity, slow rate.
        send(8'h0F, 1'b1, 1'b1, 1'b1, -1);
        repeat (10) @(posedge clk);
        #1;
        chk("sb_empty_0f", 32'(sb.size()), 32'd0);

        // Stop bit low, line held low two more bit times.
        send(8'h3C, 1'b0, 1'b0, 1'b0, -1);
        repeat (2 * DF) @(posedge clk);
        #1;
        chk("break_busy", {31'd0, busy}, 32'd1);
        chk("break_data", {24'd0, data}, 32'h0F);
        in = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("break_released", {31'd0, busy}, 32'd0);
        chk("sb_empty_3c", 32'(sb.size()), 32'd0);
        repeat (10) @(posedge clk);
        #1;

        // Short low glitch: busy for exactly half a period plus 3 cycles.
        in = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("glitch_busy", {31'd0, busy}, 32'd1);
        in = 1'b1;
        repeat (DF / 2 - 7) @(posedge clk);
        #1;
        chk("glitch_busy_late", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        chk("glitch_idle", {31'd0, busy}, 32'd0);
        repeat (DF) @(posedge clk);
        #1;

        // baud_sel flips mid-frame: this frame stays fast, next is slow.
        send(8'h5A, 1'b0, 1'b1, 1'b0, 3);
        chk("flip_sel", {31'd0, baud_sel}, 32'd1);
        send(8'hC3, 1'b0, 1'b1, 1'b1, -1);
        repeat (10) @(posedge clk);
        #1;
        chk("sb_empty_flip", 32'(sb.size()), 32'd0);

        // Back-to-back frames with no idle gap.
        send(8'h12, 1'b0, 1'b1, 1'b0, -1);
        send(8'h34, 1'b1, 1'b1, 1'b0, -1);
        repeat (10) @(posedge clk);
        #1;
        chk("sb_empty_b2b", 32'(sb.size()), 32'd0);

        // Reset in the middle of the data bits.
        baud_sel = 1'b0;
        in = 1'b0;
        repeat (DF) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            in = i[0];
            repeat (DF) @(posedge clk);
            #1;
        end
        chk("mid_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_data", {24'd0, data}, 32'h00);
        in = 1'b1;
        last_data = 8'h00;
        repeat (500) @(posedge clk);
        #1;
        chk("mrst_valid", {31'd0, valid}, 32'd0);
        chk("mrst_ferr", {31'd0, frame_err}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        send(8'h81, 1'b0, 1'b1, 1'b0, -1);
        repeat (10) @(posedge clk);
        #1;
        chk("sb_empty_end", 32'(sb.size()), 32'd0);
        chk("final_data", {24'd0, data}, 32'h81);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_frame_rx.md
UART_FRAME_RX -- requirements
Module: uart_frame_rx

Interface
REQ-001 Parameter DIV_FAST, default 46880, meaning clock cycles per bit at 9600 baud.
REQ-002 Parameter DIV_SLOW, default 93760, meaning clock cycles per bit at 4800 baud.
REQ-003 Port clk  input  1  rising-edge system clock; the block uses this one clock only.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port in  input  1  asynchronous serial line, idle high.
REQ-006 Port baud_sel  input  1  0 selects DIV_FAST, 1 selects DIV_SLOW.
REQ-007 Port data  output  8  last received payload, MSB first on the line.
REQ-008 Port valid  output  1  one-cycle pulse; data is new.
REQ-009 Port parity_err  output  1  one-cycle pulse, coincident with valid, on an even-parity mismatch.
REQ-010 Port frame_err  output  1  one-cycle pulse on a stop bit sampled low.
REQ-011 Port busy  output  1  high in every state except IDLE.

Function
REQ-012 in SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value (rx_s).
REQ-013 The frame SHALL be: start bit (0), 8 data bits MSB first, 1 even-parity bit, 1 stop bit (1).
REQ-014 The state set SHALL be: IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-015 IDLE: on the first rx_s=0, latch baud_sel into div_q, clear the bit counter, and go to START.
REQ-016 baud_sel changes after the latch in REQ-015 SHALL NOT affect the frame in progress.
REQ-017 START: after div_q/2 cycles, sample rx_s; if 0, go to DATA; if 1, treat it as a false start and return to IDLE with no output pulse.
REQ-018 DATA/PARITY/STOP: sample once every div_q cycles after the previous sample, so each sample falls at mid-bit.
REQ-019 DATA: shift samples into a shift register; after the 8th sample, go to PARITY.
REQ-020 PARITY: store the sampled bit and go to STOP.
REQ-021 STOP, sample=1: update data, pulse valid, pulse parity_err if XOR(8 data bits, parity bit)=1, and go to IDLE.
REQ-022 STOP, sample=0: pulse frame_err, leave data unchanged, do not pulse valid, and go to BREAK.
REQ-023 BREAK: wait for rx_s=1, then go to IDLE.
REQ-024 The bit-period counter SHALL be 17 bits wide, count down, and reload on every sample; there is no wrap beyond the reload.
REQ-025 Latency: valid asserts 1 cycle after the stop-bit sample, which is (10.5 x div_q)+3 cycles after the start-bit falling edge at the pin.
REQ-026 No two pulse outputs SHALL assert in the same cycle, except valid with parity_err.
REQ-027 A new start bit SHALL be accepted in the cycle after returning to IDLE; back-to-back frames SHALL NOT be lost.

Reset
REQ-028 While rst_n=0: state=IDLE, data=8'h00, valid=0, parity_err=0, frame_err=0, busy=0, synchronizer flops=1, counters=0.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no pulse; after release the block waits for a fresh falling edge.

Verification
REQ-030 baud_sel=0; send 0x A5, parity 0, stop 1, bit period 46880 -> one valid with data=8'hA5, parity_err=0, frame_err=0.
REQ-031 baud_sel=1; send 0x 0F, parity 1 (wrong) -> valid with data=8'h0F and parity_err=1 in the same cycle.
REQ-032 baud_sel=0; send 0x 3C with stop bit 0, hold line low for 2 bit times -> frame_err pulse, data unchanged, no valid; busy stays high until the line goes high.
REQ-033 Low glitch of 1000 cycles on an idle line -> START returns to IDLE, no pulse, busy low after 23440+3 cycles.
REQ-034 Toggle baud_sel 0->1 mid-frame -> frame decodes at 46880 cycles per bit; the next frame uses 93760.
REQ-035 rst_n low for 500 cycles during DATA -> all outputs at reset values; a following 0x 81 frame is received correctly.
